// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit 7-segment scan bus (display driver and
// loopback decoder): segment patterns, digit selects, capture FSM states.
package seg7_pkg;

  // Segment patterns, bit6=a ... bit0=g (dp excluded)
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  // Active-low digit selects
  localparam logic [3:0] DIG_ONES = 4'b1110;
  localparam logic [3:0] DIG_TENS = 4'b1101;

  // Decoded code for an unrecognised segment pattern
  localparam logic [3:0] CODE_INV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } cap_state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ONES,
    SEL_TENS
  } sel_t;

  // Blanking, multiple-low and unused selects all count as NONE
  function automatic sel_t classify_sel(input logic [3:0] dig);
    sel_t s;
    case (dig)
      DIG_ONES: s = SEL_ONES;
      DIG_TENS: s = SEL_TENS;
      default:  s = SEL_NONE;
    endcase
    return s;
  endfunction

  // tens*10 + ones using shifts only; tens, ones are 0..9 so the result fits 7 bits
  function automatic logic [6:0] bcd2_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] t;
    t = {3'b000, tens};
    return (t << 3) + (t << 1) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational 7-segment pattern to BCD code; unknown patterns map to CODE_INV.
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_code
);

  // Exact-match lookup against the ten legal digit patterns
  always_comb begin
    case (i_pat)
      SEG_0:   o_code = 4'd0;
      SEG_1:   o_code = 4'd1;
      SEG_2:   o_code = 4'd2;
      SEG_3:   o_code = 4'd3;
      SEG_4:   o_code = 4'd4;
      SEG_5:   o_code = 4'd5;
      SEG_6:   o_code = 4'd6;
      SEG_7:   o_code = 4'd7;
      SEG_8:   o_code = 4'd8;
      SEG_9:   o_code = 4'd9;
      default: o_code = CODE_INV;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decode.sv
// Loopback monitor for the two-digit multiplexed 7-segment scan bus.
// Synchronizes the scan lines, waits for each digit to settle, decodes it and
// reassembles a 0..99 value once per complete ones+tens frame.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no valid digit select on the bus, nothing being tracked
// ST_SETTLE | counting consecutive identical {sel, seg} samples
// ST_HELD   | digit captured, waiting for the bus to change
module seg7_scan_decode
  import seg7_pkg::*;
#(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 270_000,
  parameter int TBITS   = 19
) (
  input  logic       i_clk,
  input  logic       w_rst,
  input  logic [7:0] i_seg,
  input  logic [3:0] i_dig,
  output logic [6:0] o_value,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_chg,
  output logic       o_stale
);

  localparam int               CBITS       = $clog2(SETTLE + 1);
  localparam logic [CBITS-1:0] SETTLE_LAST = CBITS'(SETTLE - 1);
  localparam logic [TBITS-1:0] TO_MAX      = TBITS'(TIMEOUT);
  localparam logic [TBITS-1:0] TO_PRE      = TBITS'(TIMEOUT - 1);

  logic [7:0]       r_seg_s1, r_seg_s2;
  logic [3:0]       r_dig_s1, r_dig_s2;

  cap_state_t       r_state;
  logic [3:0]       r_ref_dig;
  logic [7:0]       r_ref_seg;
  logic [CBITS-1:0] r_cnt;
  logic [3:0]       r_code_ones, r_code_tens;
  logic             r_have_ones, r_have_tens;

  logic [6:0]       r_value;
  logic             r_valid, r_err, r_chg;

  logic [TBITS-1:0] r_to_cnt;
  logic             r_stale;

  sel_t             w_sel;
  logic             w_same;
  logic             w_capture;
  logic [3:0]       w_code;
  logic [6:0]       w_sum;

  // Two-flop synchronizer; resets to the blanked bus so no select is seen
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_seg_s1 <= 8'hFF;
      r_seg_s2 <= 8'hFF;
      r_dig_s1 <= 4'hF;
      r_dig_s2 <= 4'hF;
    end else begin
      r_seg_s1 <= i_seg;
      r_seg_s2 <= r_seg_s1;
      r_dig_s1 <= i_dig;
      r_dig_s2 <= r_dig_s1;
    end
  end

  assign w_sel     = classify_sel(r_dig_s2);
  assign w_same    = (r_dig_s2 == r_ref_dig) && (r_seg_s2 == r_ref_seg);
  assign w_capture = (r_state == ST_SETTLE) && w_same && (r_cnt == SETTLE_LAST);
  assign w_sum     = bcd2_to_bin(r_code_tens, r_code_ones);

  seg7_pattern_dec u_dec (
    .i_pat  (r_seg_s2[7:1]),
    .o_code (w_code)
  );

  // Capture FSM: settle each digit, latch its code and have-flag, clear flags once a frame is consumed
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state     <= ST_IDLE;
      r_ref_dig   <= 4'hF;
      r_ref_seg   <= 8'hFF;
      r_cnt       <= '0;
      r_code_ones <= CODE_INV;
      r_code_tens <= CODE_INV;
      r_have_ones <= 1'b0;
      r_have_tens <= 1'b0;
    end else begin
      if (r_have_ones && r_have_tens) begin
        r_have_ones <= 1'b0;
        r_have_tens <= 1'b0;
      end
      // IDLE and any bus change share one path so a new select starts settling immediately
      if (r_state == ST_IDLE || !w_same) begin
        if (w_sel != SEL_NONE) begin
          r_state   <= ST_SETTLE;
          r_ref_dig <= r_dig_s2;
          r_ref_seg <= r_seg_s2;
          r_cnt     <= CBITS'(1);
        end else begin
          r_state <= ST_IDLE;
        end
      end else if (r_state == ST_SETTLE) begin
        if (r_cnt == SETTLE_LAST) begin
          r_state <= ST_HELD;
          if (w_sel == SEL_TENS) begin
            r_code_tens <= w_code;
            r_have_tens <= 1'b1;
          end else begin
            r_code_ones <= w_code;
            r_have_ones <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + CBITS'(1);
        end
      end
    end
  end

  // Frame assembly: one-cycle valid/err/chg pulses the cycle after both digits are held
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_value <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_chg   <= 1'b0;
      if (r_have_ones && r_have_tens) begin
        r_valid <= 1'b1;
        if (r_code_ones != CODE_INV && r_code_tens != CODE_INV) begin
          r_value <= w_sum;
          r_chg   <= (w_sum != r_value);
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Stale timer: saturating count of cycles since the last capture; a capture always wins
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else if (w_capture) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else if (r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + TBITS'(1);
      r_stale  <= (r_to_cnt == TO_PRE);
    end
  end

  assign o_value = r_value;
  assign o_valid = r_valid;
  assign o_err   = r_err;
  assign o_chg   = r_chg;
  assign o_stale = r_stale;

endmodule

// File: tb/tb_seg7_scan_decode.sv
// Bench for seg7_scan_decode: table-driven frames, hand-written scan sequences
// and a randomized phase, all checked every cycle against a run-length model.
module tb_seg7_scan_decode;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 600;
  localparam int TBITS   = 10;

  logic       i_clk = 1'b0;
  logic       w_rst = 1'b1;
  logic [7:0] i_seg = 8'hFF;
  logic [3:0] i_dig = 4'hF;
  logic [6:0] o_value;
  logic       o_valid, o_err, o_chg, o_stale;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_decode #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .TBITS(TBITS)) dut (
    .i_clk   (i_clk),
    .w_rst   (w_rst),
    .i_seg   (i_seg),
    .i_dig   (i_dig),
    .o_value (o_value),
    .o_valid (o_valid),
    .o_err   (o_err),
    .o_chg   (o_chg),
    .o_stale (o_stale)
  );

  always #5 i_clk = ~i_clk;

  // Legal digit patterns a..g, index = digit value
  logic [6:0] pat_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  function automatic int ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (pat_tbl[i] == p) return i;
    return 15;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The FSM input stream is the pin stream delayed two clocks. A digit is
  // captured when a run of identical samples carrying a valid select reaches
  // SETTLE samples. A frame is reported the clock after both digits are held.
  logic [11:0] md1 = 12'hFFF, md2 = 12'hFFF, mprev = 12'hFFF, msamp;
  int          mrun = 0;
  int          code_o = 15, code_t = 15;
  bit          have_o = 0, have_t = 0;
  int          m_value = 0, mv;
  bit          m_valid = 0, m_err = 0, m_chg = 0, m_stale = 0;
  longint      cyc = 0, last_cap = 0;

  always @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      md1 = 12'hFFF; md2 = 12'hFFF; mprev = 12'hFFF; mrun = 0;
      code_o = 15; code_t = 15; have_o = 0; have_t = 0;
      m_value = 0; m_valid = 0; m_err = 0; m_chg = 0; m_stale = 0;
      last_cap = cyc;
    end else begin
      cyc++;
      msamp = md2; md2 = md1; md1 = {i_dig, i_seg};
      m_valid = 0; m_err = 0; m_chg = 0;
      if (have_o && have_t) begin
        m_valid = 1; have_o = 0; have_t = 0;
        if (code_o < 10 && code_t < 10) begin
          mv = code_t * 10 + code_o;
          m_chg = (mv != m_value);
          m_value = mv;
        end else begin
          m_err = 1;
        end
      end
      if (msamp == mprev) mrun++; else mrun = 1;
      mprev = msamp;
      if ((msamp[11:8] == 4'b1110 || msamp[11:8] == 4'b1101) && mrun == SETTLE) begin
        if (msamp[11:8] == 4'b1110) begin code_o = ref_decode(msamp[7:1]); have_o = 1; end
        else                        begin code_t = ref_decode(msamp[7:1]); have_t = 1; end
        last_cap = cyc;
      end
      m_stale = (cyc - last_cap) >= TIMEOUT;
    end
  end

  // Per-cycle comparison against the model, plus a record of frame pulses
  int       n_valid = 0;
  int       last_value = 0;
  bit       last_err = 0, last_chg = 0;

  always @(negedge i_clk) begin
    if (!w_rst) begin
      chk("model o_value", o_value, m_value);
      chk("model o_valid", o_valid, m_valid);
      chk("model o_err",   o_err,   m_err);
      chk("model o_chg",   o_chg,   m_chg);
      chk("model o_stale", o_stale, m_stale);
      if (o_valid) begin
        n_valid++;
        last_value = o_value;
        last_err   = o_err;
        last_chg   = o_chg;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Holds {dig, seg} on the pins for exactly n sampling edges
  task automatic drive(input logic [3:0] dig, input logic [7:0] seg, input int n);
    @(posedge i_clk); #1;
    i_dig = dig;
    i_seg = seg;
    repeat (n - 1) @(posedge i_clk);
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    w_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 w_rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] ones;
    logic [7:0] tens;
    int         value;
    bit         err;
    bit         chg;
  } frame_vec_t;

  frame_vec_t vecs [11];
  int         base;
  logic [3:0] rdig;
  logic [7:0] rseg;
  int         rn;

  initial begin
    vecs[0]  = '{8'hFC, 8'h60, 10, 1'b0, 1'b1};
    vecs[1]  = '{8'hFC, 8'h60, 10, 1'b0, 1'b0};
    vecs[2]  = '{8'h60, 8'hDA, 21, 1'b0, 1'b1};
    vecs[3]  = '{8'hFE, 8'hF2, 38, 1'b0, 1'b1};
    vecs[4]  = '{8'h66, 8'hE0, 74, 1'b0, 1'b1};
    vecs[5]  = '{8'hBE, 8'hF6, 96, 1'b0, 1'b1};
    vecs[6]  = '{8'hF7, 8'hF7, 99, 1'b0, 1'b1};
    vecs[7]  = '{8'h00, 8'h60, 99, 1'b1, 1'b0};
    vecs[8]  = '{8'h61, 8'h01, 99, 1'b1, 1'b0};
    vecs[9]  = '{8'hFC, 8'hFC,  0, 1'b0, 1'b1};
    vecs[10] = '{8'h60, 8'hFC,  1, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge i_clk);
    #1 w_rst = 1'b0;
    @(negedge i_clk);
    chk("reset o_value", o_value, 0);
    chk("reset o_valid", o_valid, 0);
    chk("reset o_stale", o_stale, 0);

    // 59 with long dwells, then an identical frame
    base = n_valid;
    drive(4'b1110, 8'hF6, 1000);
    drive(4'b1101, 8'hB6, 1000);
    @(negedge i_clk);
    chk("f59 frames", n_valid - base, 1);
    chk("f59 value", last_value, 59);
    chk("f59 chg", last_chg, 1);
    base = n_valid;
    drive(4'b1110, 8'hF6, 1000);
    drive(4'b1101, 8'hB6, 1000);
    @(negedge i_clk);
    chk("f59 repeat frames", n_valid - base, 1);
    chk("f59 repeat chg", last_chg, 0);

    // Invalid tens pattern keeps 59
    base = n_valid;
    drive(4'b1110, 8'hF6, 200);
    drive(4'b1101, 8'h02, 200);
    drive(4'b1111, 8'hFF, 8);
    @(negedge i_clk);
    chk("inv frames", n_valid - base, 1);
    chk("inv err", last_err, 1);
    chk("inv chg", last_chg, 0);
    chk("inv o_value", o_value, 59);

    // Ghosting at each select switch must not capture
    do_reset();
    base = n_valid;
    for (int i = 0; i < 3; i++) begin
      drive(4'b1110, 8'hFC, 100);
      drive(4'b1101, 8'hFC, 8);
      drive(4'b1101, 8'h60, 100);
      drive(4'b1110, 8'h60, 8);
    end
    drive(4'b1111, 8'hFF, 8);
    @(negedge i_clk);
    chk("ghost frames", n_valid - base, 3);
    chk("ghost o_value", o_value, 10);
    chk("ghost err", last_err, 0);

    // Dwell boundary: SETTLE-1 never captures, SETTLE and SETTLE+2 do
    do_reset();
    base = n_valid;
    for (int i = 0; i < 10; i++) begin
      drive(4'b1110, 8'hF6, SETTLE - 1);
      drive(4'b1101, 8'hB6, SETTLE - 1);
    end
    drive(4'b1111, 8'hFF, 8);
    @(negedge i_clk);
    chk("dwell short frames", n_valid - base, 0);
    base = n_valid;
    for (int i = 0; i < 4; i++) begin
      drive(4'b1110, 8'hF6, SETTLE);
      drive(4'b1101, 8'hB6, SETTLE);
    end
    drive(4'b1111, 8'hFF, 8);
    @(negedge i_clk);
    chk("dwell exact frames", n_valid - base, 4);
    base = n_valid;
    for (int i = 0; i < 4; i++) begin
      drive(4'b1110, 8'hF6, SETTLE + 2);
      drive(4'b1101, 8'hB6, SETTLE + 2);
    end
    drive(4'b1111, 8'hFF, 8);
    @(negedge i_clk);
    chk("dwell long frames", n_valid - base, 4);
    chk("dwell value", last_value, 59);

    // Stale after TIMEOUT idle cycles, cleared by the first capture
    drive(4'b1111, 8'hFF, TIMEOUT + 20);
    @(negedge i_clk);
    chk("stale set", o_stale, 1);
    @(posedge i_clk); #1;
    i_dig = 4'b1110;
    i_seg = 8'hF6;
    repeat (SETTLE + 1) @(posedge i_clk);
    @(negedge i_clk);
    chk("stale before capture", o_stale, 1);
    @(posedge i_clk);
    @(negedge i_clk);
    chk("stale after capture", o_stale, 0);
    drive(4'b1110, 8'hF6, 20);
    drive(4'b1101, 8'hB6, 40);

    // Reset after ones captured discards it
    do_reset();
    base = n_valid;
    drive(4'b1110, 8'hF6, 40);
    do_reset();
    drive(4'b1101, 8'hB6, 300);
    drive(4'b1111, 8'hFF, 8);
    @(negedge i_clk);
    chk("rst partial frames", n_valid - base, 0);
    drive(4'b1110, 8'hF6, 40);
    drive(4'b1111, 8'hFF, 8);
    @(negedge i_clk);
    chk("rst recapture frames", n_valid - base, 1);
    chk("rst recapture value", last_value, 59);

    // Table-driven frames
    do_reset();
    for (int k = 0; k < 11; k++) begin
      base = n_valid;
      drive(4'b1110, vecs[k].ones, 40);
      drive(4'b1101, vecs[k].tens, 40);
      drive(4'b1111, 8'hFF, 8);
      @(negedge i_clk);
      chk($sformatf("vec%0d frames", k), n_valid - base, 1);
      chk($sformatf("vec%0d o_value", k), o_value, vecs[k].value);
      chk($sformatf("vec%0d err", k), last_err, vecs[k].err);
      chk($sformatf("vec%0d chg", k), last_chg, vecs[k].chg);
    end

    // Randomized scan traffic; the model checks every cycle
    for (int k = 0; k < 400; k++) begin
      rn = $urandom_range(0, 99);
      if (rn < 40)      rdig = 4'b1110;
      else if (rn < 80) rdig = 4'b1101;
      else if (rn < 90) rdig = 4'b1111;
      else              rdig = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 80)
        rseg = {pat_tbl[$urandom_range(0, 9)], 1'($urandom_range(0, 1))};
      else
        rseg = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) do_reset();
      if (k == 200) drive(4'b1111, 8'hFF, TIMEOUT + 30);
      drive(rdig, rseg, $urandom_range(1, 40));
    end
    drive(4'b1111, 8'hFF, 8);
    @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
